// File: rtl/aes_subbytes_pipe.sv
// Pipelined AES SubBytes / InvSubBytes engine: LANES bytes per transaction,
// valid/ready on both sides, mode and tag carried alongside each transaction.
module aes_subbytes_pipe #(
  parameter int LANES      = 16,
  parameter int PIPE_DEPTH = 2,
  parameter int TAG_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   in_data,
  input  logic                 in_inv,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic                 out_inv,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy,
  output logic [15:0]          xfer_count
);

  // Entry 0 sits in the most significant byte; entry b is bits [8*(255-b) +: 8].
  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [8*LANES-1:0] substitute(input logic [8*LANES-1:0] d,
                                                    input logic              inv);
    logic [8*LANES-1:0] r;
    int                 idx;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      idx = 8 * (255 - int'(d[8*i +: 8]));
      r[8*i +: 8] = inv ? SBOX_INV[idx +: 8] : SBOX_FWD[idx +: 8];
    end
    return r;
  endfunction

  logic [PIPE_DEPTH-1:0] vld_p;
  logic [PIPE_DEPTH-1:0] inv_p;
  logic [8*LANES-1:0]    data_p [PIPE_DEPTH];
  logic [TAG_W-1:0]      tag_p  [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] load;
  logic                  rdy_en;
  logic [8*LANES-1:0]    sub_data;
  logic                  accept;

  // A stage can take new contents when it is empty or its contents move on;
  // this chains combinationally from out_ready back to in_ready.
  always_comb begin
    logic nxt;
    nxt  = out_ready;
    load = '0;
    for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
      nxt     = ~vld_p[k] | nxt;
      load[k] = nxt;
    end
  end

  assign sub_data = substitute(in_data, in_inv);
  assign in_ready = rdy_en & load[0];
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en     <= 1'b0;
      xfer_count <= '0;
      vld_p      <= '0;
      inv_p      <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        data_p[k] <= '0;
        tag_p[k]  <= '0;
      end
    end else begin
      rdy_en <= 1'b1;
      if (out_valid && out_ready)
        xfer_count <= xfer_count + 16'd1;
      // Stage 0: substituted bytes are captured on acceptance
      if (load[0]) begin
        vld_p[0] <= accept;
        if (accept) begin
          data_p[0] <= sub_data;
          inv_p[0]  <= in_inv;
          tag_p[0]  <= in_tag;
        end
      end
      // Stages 1..PIPE_DEPTH-1: plain register slices
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        if (load[k]) begin
          vld_p[k] <= vld_p[k-1];
          if (vld_p[k-1]) begin
            data_p[k] <= data_p[k-1];
            inv_p[k]  <= inv_p[k-1];
            tag_p[k]  <= tag_p[k-1];
          end
        end
      end
    end
  end

  assign out_valid = vld_p[PIPE_DEPTH-1];
  assign out_data  = data_p[PIPE_DEPTH-1];
  assign out_inv   = inv_p[PIPE_DEPTH-1];
  assign out_tag   = tag_p[PIPE_DEPTH-1];
  assign busy      = |vld_p;

endmodule
